// File: rtl/reg_window_ctrl.sv
// ----------------------------------------------------------------------------
// reg_window_ctrl
//   SPARC V8 register-window controller for the IU register file.
//   Holds CWP and WIM, sequences SAVE / RESTORE / RETT window moves, raises a
//   window overflow (tt=0x05) or underflow (tt=0x06) trap request and holds it
//   until the trap unit acknowledges, and maps logical register numbers to
//   physical register-file indices.
//
// Ports
//   Clk, Clr            clock (rising edge), asynchronous active-low reset
//   save/restore/rett   window-move commands (at most one per cycle in IDLE)
//   wr_cwp, cwp_in      WRPSR load of CWP (wins over any command/ack)
//   wr_wim, wim_in      WRWIM load of WIM
//   trap_ack            trap unit accepts the pending window trap
//   rs1, rs2, rd        logical register numbers 0..31
//   cwp, wim            current window pointer, window invalid mask
//   trap_req, trap_tt   pending window trap and its trap type
//   busy                IU must stall while a window trap is pending
//   ps1, ps2, pd        physical register indices for rs1 / rs2 / rd
// ----------------------------------------------------------------------------
module reg_window_ctrl #(
   parameter int NWINDOWS = 8,
   parameter int CWPW     = 3,
   parameter int PHYW     = 8
) (
   input  logic                Clk,
   input  logic                Clr,
   input  logic                save,
   input  logic                restore,
   input  logic                rett,
   input  logic                wr_cwp,
   input  logic [CWPW-1:0]     cwp_in,
   input  logic                wr_wim,
   input  logic [NWINDOWS-1:0] wim_in,
   input  logic                trap_ack,
   input  logic [4:0]          rs1,
   input  logic [4:0]          rs2,
   input  logic [4:0]          rd,
   output logic [CWPW-1:0]     cwp,
   output logic [NWINDOWS-1:0] wim,
   output logic                trap_req,
   output logic [7:0]          trap_tt,
   output logic                busy,
   output logic [PHYW-1:0]     ps1,
   output logic [PHYW-1:0]     ps2,
   output logic [PHYW-1:0]     pd
);

   typedef enum logic {IDLE, TRAP_PEND} state_e;

   localparam logic [7:0] TT_OVF = 8'h05;
   localparam logic [7:0] TT_UNF = 8'h06;
   localparam logic [NWINDOWS-1:0] WIM_RST = NWINDOWS'(2);

   state_e                state_q, state_d;
   logic [CWPW-1:0]       cwp_q, cwp_d;
   logic [NWINDOWS-1:0]   wim_q, wim_d;
   logic [7:0]            tt_q, tt_d;

   // Window neighbours; CWPW-bit arithmetic wraps modulo NWINDOWS for free.
   logic [CWPW-1:0]       cwp_dec, cwp_inc;
   assign cwp_dec = cwp_q - CWPW'(1);
   assign cwp_inc = cwp_q + CWPW'(1);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q <= IDLE;
         cwp_q   <= '0;
         wim_q   <= WIM_RST;
         tt_q    <= '0;
      end else begin
         state_q <= state_d;
         cwp_q   <= cwp_d;
         wim_q   <= wim_d;
         tt_q    <= tt_d;
      end
   end

   // Next-state logic.
   // NOTE: every variable gets a hold default up front so no path through the
   // case/if tree can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cwp_d   = cwp_q;
      wim_d   = wim_q;
      tt_d    = tt_q;

      // The overflow/underflow checks below read wim_q, so a same-cycle
      // WRWIM never affects the command issued alongside it.
      if (wr_wim) wim_d = wim_in;

      // WRPSR wins: any command or trap acknowledge in the same cycle is
      // dropped and the FSM stays where it is.
      if (wr_cwp) begin
         cwp_d = cwp_in;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (save) begin
                  if (wim_q[cwp_dec]) begin
                     state_d = TRAP_PEND;
                     tt_d    = TT_OVF;
                  end else begin
                     cwp_d = cwp_dec;
                  end
               end else if (restore || rett) begin
                  if (wim_q[cwp_inc]) begin
                     state_d = TRAP_PEND;
                     tt_d    = TT_UNF;
                  end else begin
                     cwp_d = cwp_inc;
                  end
               end
            end
            TRAP_PEND: begin
               // Trap entry always moves to the previous window, ignoring WIM.
               if (trap_ack) begin
                  state_d = IDLE;
                  cwp_d   = cwp_dec;
                  tt_d    = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output logic.
   always_comb begin
      trap_req = 1'b0;
      busy     = 1'b0;
      trap_tt  = 8'h00;
      if (state_q == TRAP_PEND) begin
         trap_req = 1'b1;
         busy     = 1'b1;
         trap_tt  = tt_q;
      end
   end

   assign cwp = cwp_q;
   assign wim = wim_q;

   // Globals map straight through; windowed registers slide by 16 per window
   // modulo the 16*NWINDOWS windowed bank, so the ins (r24-31) of window w
   // land on the outs (r8-15) of window w+1.
   function automatic logic [PHYW-1:0] map_reg(input logic [4:0] r,
                                                input logic [CWPW-1:0] w);
      logic [CWPW+3:0] off;
      if (r < 5'd8) begin
         map_reg = PHYW'(r);
      end else begin
         off     = {w, 4'b0000} + (CWPW+4)'(r - 5'd8);
         map_reg = PHYW'(off) + PHYW'(8);
      end
   endfunction

   assign ps1 = map_reg(rs1, cwp_q);
   assign ps2 = map_reg(rs2, cwp_q);
   assign pd  = map_reg(rd,  cwp_q);

   // Only one window-move command may be presented while the FSM is idle.
   a_one_cmd : assert property (@(posedge Clk) disable iff (!Clr)
      (state_q == IDLE) |-> $onehot0({save, restore, rett}));

endmodule

// File: tb/tb_reg_window_ctrl.sv
module tb_reg_window_ctrl;

   localparam int NW = 8;

   logic       Clk = 1'b0;
   logic       Clr = 1'b0;
   logic       save = 0, restore = 0, rett = 0, wr_cwp = 0, wr_wim = 0, trap_ack = 0;
   logic [2:0] cwp_in = '0;
   logic [7:0] wim_in = '0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic [2:0] cwp;
   logic [7:0] wim;
   logic       trap_req, busy;
   logic [7:0] trap_tt;
   logic [7:0] ps1, ps2, pd;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   reg_window_ctrl dut (
      .Clk(Clk), .Clr(Clr), .save(save), .restore(restore), .rett(rett),
      .wr_cwp(wr_cwp), .cwp_in(cwp_in), .wr_wim(wr_wim), .wim_in(wim_in),
      .trap_ack(trap_ack), .rs1(rs1), .rs2(rs2), .rd(rd),
      .cwp(cwp), .wim(wim), .trap_req(trap_req), .trap_tt(trap_tt),
      .busy(busy), .ps1(ps1), .ps2(ps2), .pd(pd)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_cwp;
   bit m_wim[NW];
   bit m_pend;
   int m_tt;

   function automatic int exp_phys(input int r, input int c);
      if (r < 8) return r;
      return 8 + ((16 * c + r - 8) % (16 * NW));
   endfunction

   function automatic int wim_val();
      int v = 0;
      for (int i = 0; i < NW; i++) if (m_wim[i]) v += (1 << i);
      return v;
   endfunction

   always @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         m_cwp = 0;
         for (int i = 0; i < NW; i++) m_wim[i] = (i == 1);
         m_pend = 0;
         m_tt = 0;
      end else begin
         int n_cwp, n_tt, tgt;
         bit n_pend;
         bit old_wim[NW];
         n_cwp = m_cwp; n_pend = m_pend; n_tt = m_tt;
         old_wim = m_wim;
         if (wr_wim) for (int i = 0; i < NW; i++) m_wim[i] = wim_in[i];
         if (wr_cwp) begin
            n_cwp = int'(cwp_in);
         end else if (m_pend) begin
            if (trap_ack) begin
               n_cwp = (m_cwp + NW - 1) % NW;
               n_pend = 0;
               n_tt = 0;
            end
         end else if (save) begin
            tgt = (m_cwp + NW - 1) % NW;
            if (old_wim[tgt]) begin n_pend = 1; n_tt = 5; end
            else n_cwp = tgt;
         end else if (restore || rett) begin
            tgt = (m_cwp + 1) % NW;
            if (old_wim[tgt]) begin n_pend = 1; n_tt = 6; end
            else n_cwp = tgt;
         end
         m_cwp = n_cwp; m_pend = n_pend; m_tt = n_tt;
      end
   end

   // Per-cycle compare, half a period away from the active edge.
   always @(negedge Clk) begin
      if (chk_en) begin
         check("cwp",      int'(cwp),      m_cwp);
         check("wim",      int'(wim),      wim_val());
         check("trap_req", int'(trap_req), int'(m_pend));
         check("busy",     int'(busy),     int'(m_pend));
         check("trap_tt",  int'(trap_tt),  m_tt);
         check("ps1",      int'(ps1),      exp_phys(int'(rs1), m_cwp));
         check("ps2",      int'(ps2),      exp_phys(int'(rs2), m_cwp));
         check("pd",       int'(pd),       exp_phys(int'(rd),  m_cwp));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_cmds();
      save = 0; restore = 0; rett = 0; wr_cwp = 0; wr_wim = 0; trap_ack = 0;
   endtask

   // Let the current inputs take effect on n edges, then settle just after
   // the following falling edge and drop all command strobes.
   task automatic tick(input int n = 1);
      repeat (n) @(posedge Clk);
      @(negedge Clk);
      #1;
      clear_cmds();
   endtask

   task automatic load(input int c, input bit do_wim, input int w);
      wr_cwp = 1; cwp_in = 3'(c);
      wr_wim = do_wim; wim_in = 8'(w);
      tick();
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge Clk);
      #1;
      chk_en = 1;
      check("rst_cwp", int'(cwp), 0);
      check("rst_wim", int'(wim), 2);
      check("rst_trap_req", int'(trap_req), 0);
      check("rst_tt", int'(trap_tt), 0);
      check("rst_busy", int'(busy), 0);
      Clr = 1;
      tick();

      // 1. save from cwp 0 wraps to 7
      save = 1; tick();
      check("t1_cwp", int'(cwp), 7);
      check("t1_trap", int'(trap_req), 0);
      rs1 = 5'd8; #1;
      check("t1_ps1", int'(ps1), 120);

      // 2. overflow trap, held, then acknowledged
      load(2, 0, 0);
      save = 1; tick();
      check("t2_req", int'(trap_req), 1);
      check("t2_tt", int'(trap_tt), 5);
      check("t2_busy", int'(busy), 1);
      check("t2_cwp", int'(cwp), 2);
      restore = 1; tick();       // ignored while pending
      tick(2);
      check("t2_hold_cwp", int'(cwp), 2);
      check("t2_hold_req", int'(trap_req), 1);
      trap_ack = 1; tick();
      check("t2_ack_cwp", int'(cwp), 1);
      check("t2_ack_req", int'(trap_req), 0);
      check("t2_ack_tt", int'(trap_tt), 0);

      // 3. underflow at wrap-around, then clean wrap
      load(7, 1, 8'h01);
      restore = 1; tick();
      check("t3_tt", int'(trap_tt), 6);
      check("t3_cwp", int'(cwp), 7);
      trap_ack = 1; tick();
      check("t3_ack_cwp", int'(cwp), 6);
      load(7, 1, 8'h00);
      restore = 1; tick();
      check("t3_wrap_cwp", int'(cwp), 0);
      check("t3_wrap_req", int'(trap_req), 0);
      rett = 1; tick();
      check("t3_rett_cwp", int'(cwp), 1);

      // 4. window aliasing
      rs1 = 5'd24; rs2 = 5'd8; rd = 5'd31;
      load(3, 0, 0);
      check("t4_ins_w3", int'(ps1), 72);
      load(4, 0, 0);
      check("t4_outs_w4", int'(ps2), 72);
      load(7, 0, 0);
      check("t4_r31_w7", int'(pd), 15);
      rs1 = 5'd5; #1;
      check("t4_global", int'(ps1), 5);

      // 5. same-cycle priority
      wim_in = 8'h00; wr_wim = 1; tick();
      wr_wim = 1; wim_in = 8'h40;  // would make target 6 invalid, uses old wim
      wr_cwp = 1; cwp_in = 3'd5; save = 1; tick();
      check("t5_wrcwp", int'(cwp), 5);
      check("t5_wrcwp_req", int'(trap_req), 0);
      load(5, 1, 8'h00);
      wr_wim = 1; wim_in = 8'hFF; save = 1; tick();
      check("t5_oldwim_cwp", int'(cwp), 4);
      check("t5_wim", int'(wim), 8'hFF);
      save = 1; tick();
      check("t5_ovf", int'(trap_tt), 5);
      wr_cwp = 1; cwp_in = 3'd2; trap_ack = 1; tick();
      check("t5_ack_dropped_cwp", int'(cwp), 2);
      check("t5_ack_dropped_req", int'(trap_req), 1);

      // 6. async reset mid-trap, no clock edge
      Clr = 0;
      #2;
      check("t6_cwp", int'(cwp), 0);
      check("t6_wim", int'(wim), 2);
      check("t6_req", int'(trap_req), 0);
      check("t6_tt", int'(trap_tt), 0);
      check("t6_busy", int'(busy), 0);
      tick();
      Clr = 1;
      tick();

      // Mapping sweep across every window
      load(0, 1, 8'h00);
      for (int c = 0; c < NW; c++) begin
         for (int i = 0; i < 8; i++) begin
            rs1 = 5'(i); rs2 = 5'(i + 8); rd = 5'(i + 24 - (c % 2) * 8);
            if (i == 0) begin wr_cwp = 1; cwp_in = 3'(c); end
            tick();
         end
      end

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
